// File: rtl/mem_array_ctrl.sv
// Request controller for a shared-bus array of soft-associative memory cells.
// Broadcasts one request at a time, merges the cells' decision and answers with a status code.
module mem_array_ctrl #(
   parameter int unsigned BIT_WIDTH      = 512,
   parameter int unsigned NUM_CELLS      = 16,
   parameter int unsigned LOG_NUM_CELLS  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           rstb,
   input  logic                           reqValid,
   output logic                           reqReady,
   input  logic                           reqWnr,
   input  logic [BIT_WIDTH-1:0]           reqAddress,
   output logic                           respValid,
   input  logic                           respReady,
   output logic [2:0]                     respStatus,
   output logic [BIT_WIDTH-1:0]           respData,
   output logic [LOG_NUM_CELLS-1:0]       respIndex,
   output logic [LOG_NUM_CELLS:0]         respHitCount,
   output logic [BIT_WIDTH-1:0]           cellAddress,
   output logic                           cellValid,
   output logic                           cellWnr,
   output logic [NUM_CELLS-1:0]           cellSetAddress,
   output logic [NUM_CELLS-1:0]           cellOtherHit,
   input  logic [NUM_CELLS-1:0]           cellHit,
   input  logic [NUM_CELLS-1:0]           cellDecisionValid,
   input  logic [NUM_CELLS-1:0]           cellLocationEmpty,
   input  logic [NUM_CELLS*BIT_WIDTH-1:0] cellRdata
);

   localparam int unsigned HcW  = LOG_NUM_CELLS + 1;
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [2:0] StatReadHit       = 3'd0;
   localparam logic [2:0] StatReadMiss      = 3'd1;
   localparam logic [2:0] StatWriteUpdate   = 3'd2;
   localparam logic [2:0] StatWriteAlloc    = 3'd3;
   localparam logic [2:0] StatWriteFull     = 3'd4;
   localparam logic [2:0] StatWriteConflict = 3'd5;
   localparam logic [2:0] StatTimeout       = 3'd6;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StAlloc,
      StResp
   } state_e;

   state_e                   state_q;
   logic [BIT_WIDTH-1:0]     addr_q;
   logic                     wnr_q;
   logic                     cell_valid_q;
   logic [NUM_CELLS-1:0]     set_addr_q;
   logic                     req_ready_q;
   logic                     resp_valid_q;
   logic [2:0]               resp_status_q;
   logic [BIT_WIDTH-1:0]     resp_data_q;
   logic [LOG_NUM_CELLS-1:0] resp_index_q;
   logic [HcW-1:0]           resp_hc_q;
   logic [CntW-1:0]          cnt_q;

   logic                     decision;
   logic [HcW-1:0]           hit_count;
   logic [BIT_WIDTH-1:0]     merged_data;
   logic                     any_empty;
   logic [LOG_NUM_CELLS-1:0] empty_idx;
   logic [NUM_CELLS-1:0]     empty_onehot;
   logic [NUM_CELLS-1:0]     other_hit;
   logic [NUM_CELLS-1:0]     hit_masked;

   // Decisions are only meaningful while waiting; late strobes in other states are dropped.
   assign decision = (state_q == StWait) && (|cellDecisionValid);

   always_comb begin
      hit_count   = '0;
      merged_data = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         hit_count   = hit_count + {{LOG_NUM_CELLS{1'b0}}, cellHit[i]};
         merged_data = merged_data | cellRdata[i*BIT_WIDTH +: BIT_WIDTH];
      end
   end

   always_comb begin
      any_empty = 1'b0;
      empty_idx = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (!any_empty && cellLocationEmpty[i]) begin
            any_empty = 1'b1;
            empty_idx = LOG_NUM_CELLS'(i);
         end
      end
      empty_onehot            = '0;
      empty_onehot[empty_idx] = 1'b1;
   end

   always_comb begin
      other_hit  = '0;
      hit_masked = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         hit_masked    = cellHit;
         hit_masked[i] = 1'b0;
         other_hit[i]  = decision & (|hit_masked);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         wnr_q         <= 1'b0;
         cell_valid_q  <= 1'b0;
         set_addr_q    <= '0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_status_q <= '0;
         resp_data_q   <= '0;
         resp_index_q  <= '0;
         resp_hc_q     <= '0;
         cnt_q         <= '0;
      end else begin
         // Single-cycle strobes default low.
         cell_valid_q <= 1'b0;
         set_addr_q   <= '0;
         unique case (state_q)
            StIdle: begin
               if (reqValid) begin
                  addr_q        <= reqAddress;
                  wnr_q         <= reqWnr;
                  req_ready_q   <= 1'b0;
                  cell_valid_q  <= 1'b1;
                  resp_status_q <= '0;
                  resp_data_q   <= '0;
                  resp_index_q  <= '0;
                  resp_hc_q     <= '0;
                  state_q       <= StIssue;
               end
            end
            StIssue: begin
               cnt_q   <= '0;
               state_q <= StWait;
            end
            StWait: begin
               if (decision) begin
                  resp_hc_q <= hit_count;
                  if (!wnr_q) begin
                     if (hit_count != '0) begin
                        resp_status_q <= StatReadHit;
                        resp_data_q   <= merged_data;
                     end else begin
                        resp_status_q <= StatReadMiss;
                     end
                     resp_valid_q <= 1'b1;
                     state_q      <= StResp;
                  end else if (hit_count == HcW'(1)) begin
                     resp_status_q <= StatWriteUpdate;
                     resp_valid_q  <= 1'b1;
                     state_q       <= StResp;
                  end else if (hit_count != '0) begin
                     resp_status_q <= StatWriteConflict;
                     resp_valid_q  <= 1'b1;
                     state_q       <= StResp;
                  end else if (any_empty) begin
                     resp_index_q  <= empty_idx;
                     resp_status_q <= StatWriteAlloc;
                     set_addr_q    <= empty_onehot;
                     state_q       <= StAlloc;
                  end else begin
                     resp_status_q <= StatWriteFull;
                     resp_valid_q  <= 1'b1;
                     state_q       <= StResp;
                  end
               end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  resp_status_q <= StatTimeout;
                  resp_valid_q  <= 1'b1;
                  state_q       <= StResp;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StAlloc: begin
               resp_valid_q <= 1'b1;
               state_q      <= StResp;
            end
            StResp: begin
               if (respReady) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign reqReady       = req_ready_q;
   assign respValid      = resp_valid_q;
   assign respStatus     = resp_status_q;
   assign respData       = resp_data_q;
   assign respIndex      = resp_index_q;
   assign respHitCount   = resp_hc_q;
   assign cellAddress    = addr_q;
   assign cellValid      = cell_valid_q;
   assign cellWnr        = wnr_q;
   assign cellSetAddress = set_addr_q;
   assign cellOtherHit   = other_hit;

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Directed bench for mem_array_ctrl: a cell-array stand-in drives decisions while a
// scoreboard queue holds the response expected for each issued request.
module tb_mem_array_ctrl;

   localparam int unsigned BW  = 512;
   localparam int unsigned NC  = 16;
   localparam int unsigned LNC = 4;
   localparam int unsigned TO  = 64;

   logic              clk = 1'b0;
   logic              rstb;
   logic              reqValid;
   logic              reqReady;
   logic              reqWnr;
   logic [BW-1:0]     reqAddress;
   logic              respValid;
   logic              respReady;
   logic [2:0]        respStatus;
   logic [BW-1:0]     respData;
   logic [LNC-1:0]    respIndex;
   logic [LNC:0]      respHitCount;
   logic [BW-1:0]     cellAddress;
   logic              cellValid;
   logic              cellWnr;
   logic [NC-1:0]     cellSetAddress;
   logic [NC-1:0]     cellOtherHit;
   logic [NC-1:0]     cellHit;
   logic [NC-1:0]     cellDecisionValid;
   logic [NC-1:0]     cellLocationEmpty;
   logic [NC*BW-1:0]  cellRdata;

   typedef struct {
      logic [2:0]     st;
      logic [BW-1:0]  data;
      logic [LNC-1:0] idx;
      logic [LNC:0]   hc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   mem_array_ctrl #(
      .BIT_WIDTH      (BW),
      .NUM_CELLS      (NC),
      .LOG_NUM_CELLS  (LNC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk               (clk),
      .rstb              (rstb),
      .reqValid          (reqValid),
      .reqReady          (reqReady),
      .reqWnr            (reqWnr),
      .reqAddress        (reqAddress),
      .respValid         (respValid),
      .respReady         (respReady),
      .respStatus        (respStatus),
      .respData          (respData),
      .respIndex         (respIndex),
      .respHitCount      (respHitCount),
      .cellAddress       (cellAddress),
      .cellValid         (cellValid),
      .cellWnr           (cellWnr),
      .cellSetAddress    (cellSetAddress),
      .cellOtherHit      (cellOtherHit),
      .cellHit           (cellHit),
      .cellDecisionValid (cellDecisionValid),
      .cellLocationEmpty (cellLocationEmpty),
      .cellRdata         (cellRdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference for otherHit: bit i set when any cell other than i hits.
   function automatic logic [NC-1:0] model_oh(input logic [NC-1:0] h);
      logic [NC-1:0] r;
      logic [NC-1:0] m;
      r = '0;
      for (int i = 0; i < NC; i++) begin
         m    = h;
         m[i] = 1'b0;
         r[i] = |m;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request/response. dly < 0 means the cells never decide.
   task automatic run_txn(input string name, input logic wnr, input logic [BW-1:0] addr,
                          input logic [NC-1:0] hit, input logic [NC-1:0] empty,
                          input logic [NC*BW-1:0] rdata, input int dly,
                          input logic [2:0] est, input logic [BW-1:0] edata,
                          input logic [LNC-1:0] eidx, input logic [LNC:0] ehc,
                          input logic [NC-1:0] esa, input int hold);
      exp_t e;
      exp_t got;
      int   n;
      logic [2:0]     h_st;
      logic [BW-1:0]  h_data;
      logic [LNC-1:0] h_idx;
      logic [LNC:0]   h_hc;
      n = 0;
      while (!reqReady && n < 50) begin
         step();
         n++;
      end
      chk({name, ".req_ready"}, reqReady, 1'b1);
      e.st = est; e.data = edata; e.idx = eidx; e.hc = ehc;
      sb.push_back(e);
      respReady  = (hold == 0);
      reqValid   = 1'b1;
      reqWnr     = wnr;
      reqAddress = addr;
      step();
      reqValid   = 1'b0;
      reqWnr     = ~wnr;
      reqAddress = ~addr;
      chk({name, ".issue_valid"}, cellValid, 1'b1);
      chk({name, ".issue_addr"}, cellAddress, addr);
      chk({name, ".issue_wnr"}, cellWnr, wnr);
      step();
      chk({name, ".valid_pulse"}, cellValid, 1'b0);
      if (dly < 0) begin
         n = 0;
         while (!respValid && n < int'(TO) + 10) begin
            step();
            n++;
         end
         chk({name, ".timeout_cycles"}, n, TO);
      end else begin
         repeat (dly) step();
         cellHit           = hit;
         cellLocationEmpty = empty;
         cellRdata         = rdata;
         cellDecisionValid = '1;
         #1;
         chk({name, ".other_hit"}, cellOtherHit, model_oh(hit));
         step();
         cellDecisionValid = '0;
         cellHit           = '0;
         cellRdata         = '0;
         cellLocationEmpty = '0;
         chk({name, ".set_addr"}, cellSetAddress, esa);
         if (esa != '0) begin
            chk({name, ".alloc_addr"}, cellAddress, addr);
            step();
            chk({name, ".set_addr_pulse"}, cellSetAddress, '0);
         end
         chk({name, ".latency"}, respValid, 1'b1);
      end
      n = 0;
      while (!respValid && n < int'(TO) + 10) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk({name, ".status"}, respStatus, got.st);
         chk({name, ".data"}, respData, got.data);
         chk({name, ".index"}, respIndex, got.idx);
         chk({name, ".hit_count"}, respHitCount, got.hc);
      end
      chk({name, ".bus_hold"}, cellAddress, addr);
      if (hold > 0) begin
         h_st = respStatus; h_data = respData; h_idx = respIndex; h_hc = respHitCount;
         repeat (hold) begin
            step();
            chk({name, ".hold_valid"}, respValid, 1'b1);
            chk({name, ".hold_status"}, respStatus, h_st);
            chk({name, ".hold_data"}, respData, h_data);
            chk({name, ".hold_index"}, respIndex, h_idx);
            chk({name, ".hold_hc"}, respHitCount, h_hc);
            chk({name, ".hold_req_ready"}, reqReady, 1'b0);
         end
         respReady = 1'b1;
      end
      step();
      chk({name, ".resp_drop"}, respValid, 1'b0);
      chk({name, ".back_idle"}, reqReady, 1'b1);
   endtask

   logic [BW-1:0]    a_val;
   logic [BW-1:0]    b_val;
   logic [BW-1:0]    c_val;
   logic [NC*BW-1:0] rd;

   initial begin
      a_val = {16{32'hA5A5_0F0F}};
      b_val = {8{64'h0123_4567_89AB_CDEF}};
      c_val = {32{16'h5A3C}};
      rstb = 1'b0;
      reqValid = 1'b0; reqWnr = 1'b0; reqAddress = '0; respReady = 1'b1;
      cellHit = '0; cellDecisionValid = '0; cellLocationEmpty = '0; cellRdata = '0;
      #12;
      chk("reset.req_ready", reqReady, 1'b1);
      chk("reset.resp_valid", respValid, 1'b0);
      chk("reset.cell_valid", cellValid, 1'b0);
      chk("reset.cell_addr", cellAddress, '0);
      chk("reset.status", respStatus, '0);
      @(posedge clk);
      #1;
      rstb = 1'b1;
      step();

      run_txn("alloc_first", 1'b1, a_val, '0, '1, '0, 0, 3'd3, '0, 4'd0, 5'd0, 16'h0001, 0);

      rd = '0;
      rd[5*BW +: BW] = a_val;
      run_txn("read_hit5", 1'b0, a_val, 16'h0020, '0, rd, 2, 3'd0, a_val, 4'd0, 5'd1, '0, 0);

      run_txn("conflict", 1'b1, b_val, 16'h0084, '1, '0, 1, 3'd5, '0, 4'd0, 5'd2, '0, 0);
      run_txn("full", 1'b1, b_val, '0, '0, '0, 0, 3'd4, '0, 4'd0, 5'd0, '0, 0);
      run_txn("alloc_idx3", 1'b1, c_val, '0, 16'b0100_1000, '0, 3, 3'd3, '0, 4'd3, 5'd0,
              16'h0008, 0);

      rd = '0;
      rd[9*BW +: BW] = b_val;
      run_txn("update", 1'b1, c_val, 16'h0200, '1, rd, 0, 3'd2, '0, 4'd0, 5'd1, '0, 0);

      rd = '1;
      run_txn("read_miss", 1'b0, b_val, '0, '1, rd, 4, 3'd1, '0, 4'd0, 5'd0, '0, 0);

      rd = '0;
      rd[1*BW +: BW] = a_val;
      rd[9*BW +: BW] = c_val;
      run_txn("read_or_hold", 1'b0, c_val, 16'h0202, '0, rd, 1, 3'd0, a_val | c_val, 4'd0,
              5'd2, '0, 5);

      rd = '0;
      rd[0 +: BW] = b_val;
      run_txn("edge_decision", 1'b0, b_val, 16'h0001, '0, rd, TO - 1, 3'd0, b_val, 4'd0,
              5'd1, '0, 0);

      run_txn("timeout", 1'b0, a_val, '0, '0, '0, -1, 3'd6, '0, 4'd0, 5'd0, '0, 0);

      // Late decision after the timeout must be ignored.
      cellHit = 16'h0003;
      cellDecisionValid = '1;
      rd = '0;
      rd[0 +: BW] = a_val;
      cellRdata = rd;
      #1;
      chk("late.other_hit", cellOtherHit, '0);
      repeat (3) begin
         step();
         chk("late.no_resp", respValid, 1'b0);
      end
      cellHit = '0; cellDecisionValid = '0; cellRdata = '0;

      // Reset mid-WAIT aborts with no response.
      reqValid = 1'b1; reqWnr = 1'b1; reqAddress = c_val;
      step();
      reqValid = 1'b0;
      step();
      repeat (3) step();
      chk("abort.in_wait_addr", cellAddress, c_val);
      cellHit = 16'h0005;
      cellDecisionValid = 16'h0001;
      #2;
      rstb = 1'b0;
      #1;
      chk("abort.req_ready", reqReady, 1'b1);
      chk("abort.resp_valid", respValid, 1'b0);
      chk("abort.cell_addr", cellAddress, '0);
      chk("abort.cell_wnr", cellWnr, 1'b0);
      chk("abort.other_hit", cellOtherHit, '0);
      chk("abort.set_addr", cellSetAddress, '0);
      cellHit = '0;
      cellDecisionValid = '0;
      @(posedge clk);
      #1;
      rstb = 1'b1;
      repeat (3) begin
         step();
         chk("abort.no_resp", respValid, 1'b0);
      end

      run_txn("post_reset", 1'b1, a_val, '0, 16'h8000, '0, 0, 3'd3, '0, 4'd15, 5'd0,
              16'h8000, 0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
